aes_stream_fifo: RTL and testbench

- Parametrised successor to the fixed 8-bit x 16 data buffer in the AES encryptor datapath.
- Buffers words between the USB receive side (writer) and the AES block loader (reader).
- Adds generic width and depth (non-power-of-two depth allowed), first-word-fall-through read, occupancy count, programmable almost-full/almost-empty watermarks, synchronous flush, and sticky overflow/underflow error flags.

---
 rtl/aes_stream_fifo.sv | 106 ++++++++++
 tb/tb_aes_stream_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_fifo.sv
// First-word-fall-through word buffer between the USB receive side and the AES block loader.
// Arbitrary depth up to 2^ADDR_W, with occupancy count, watermarks, flush and sticky error flags.
module aes_stream_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              w_enable,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_enable,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    generate
        if (DEPTH < 2 || DEPTH > (1 << ADDR_W) || AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_bad_params
            $error("aes_stream_fifo: illegal DEPTH/ADDR_W/AF_THRESH/AE_THRESH combination");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_CNT   = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0]   AE_CNT   = (ADDR_W + 1)'(AE_THRESH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_wr_ok;
    logic              w_rd_ok;

    // Pointers wrap at DEPTH-1 rather than at the power of two, so odd depths work.
    function automatic logic [ADDR_W-1:0] nextPtr(input logic [ADDR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
    endfunction

    assign empty        = (r_count == '0);
    assign full         = (r_count == FULL_CNT);
    assign almost_full  = (r_count >= AF_CNT);
    assign almost_empty = (r_count <= AE_CNT);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign r_data       = empty ? '0 : r_mem[r_rptr];

    // A write into a full buffer is still accepted when a read frees the head slot the same cycle.
    always_comb begin
        w_wr_ok = w_enable & (~full | r_enable);
        w_rd_ok = r_enable & ~empty;
    end

    always_ff @(posedge clk) begin
        if (!clear && w_wr_ok) begin
            r_mem[r_wptr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rptr      <= '0;
            r_wptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_rptr      <= '0;
            r_wptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= nextPtr(r_wptr);
            end
            if (w_rd_ok) begin
                r_rptr <= nextPtr(r_rptr);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_enable && full && !r_enable) begin
                r_overflow <= 1'b1;
            end
            if (r_enable && empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_stream_fifo.sv
// Bench for aes_stream_fifo: a 16-deep and a 12-deep instance driven by directed and random traffic,
// checked every cycle against a list-based occupancy model.
module tb_aes_stream_fifo;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       clr [2];
    logic       we  [2];
    logic [7:0] wd  [2];
    logic       re  [2];
    logic [7:0] rd  [2];
    logic       emp [2];
    logic       ful [2];
    logic       af  [2];
    logic       ae  [2];
    logic [4:0] cnt [2];
    logic       ovf [2];
    logic       udf [2];

    int checks = 0;
    int errors = 0;

    // Model: each instance is an ever-growing list (head index + occupancy) over a 64-entry ring.
    logic [7:0] mData [2][64];
    int         mHead [2];
    int         mCnt  [2];
    bit         mOvf  [2];
    bit         mUdf  [2];

    always #5 clk = ~clk;

    aes_stream_fifo dut16 (
        .clk(clk), .n_rst(n_rst), .clear(clr[0]), .w_enable(we[0]), .w_data(wd[0]),
        .r_enable(re[0]), .r_data(rd[0]), .empty(emp[0]), .full(ful[0]),
        .almost_full(af[0]), .almost_empty(ae[0]), .count(cnt[0]),
        .overflow(ovf[0]), .underflow(udf[0])
    );

    aes_stream_fifo #(.DATA_W(8), .DEPTH(12), .ADDR_W(4), .AF_THRESH(9), .AE_THRESH(3)) dut12 (
        .clk(clk), .n_rst(n_rst), .clear(clr[1]), .w_enable(we[1]), .w_data(wd[1]),
        .r_enable(re[1]), .r_data(rd[1]), .empty(emp[1]), .full(ful[1]),
        .almost_full(af[1]), .almost_empty(ae[1]), .count(cnt[1]),
        .overflow(ovf[1]), .underflow(udf[1])
    );

    function automatic int depthOf(input int k);
        return (k == 0) ? 16 : 12;
    endfunction

    function automatic int afOf(input int k);
        return (k == 0) ? 12 : 9;
    endfunction

    function automatic int aeOf(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    task automatic checkOutput(input string name, input int k, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s dut%0d at %0t: got %0h expected %0h", name, k, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int k, input logic c, input logic w, input logic [7:0] d, input logic r);
        clr[k] = c;
        we[k]  = w;
        wd[k]  = d;
        re[k]  = r;
        @(negedge clk);
        clr[k] = 1'b0;
        we[k]  = 1'b0;
        re[k]  = 1'b0;
    endtask

    // Model update on every rising edge, straight from the accept rules.
    always @(posedge clk or negedge n_rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!n_rst) begin
                mCnt[k] = 0;
                mOvf[k] = 1'b0;
                mUdf[k] = 1'b0;
            end else if (clr[k]) begin
                mCnt[k] = 0;
                mOvf[k] = 1'b0;
                mUdf[k] = 1'b0;
            end else begin
                bit isFull, isEmpty, wr, rdOk;
                isFull  = (mCnt[k] == depthOf(k));
                isEmpty = (mCnt[k] == 0);
                wr      = we[k] && (!isFull || re[k]);
                rdOk    = re[k] && !isEmpty;
                if (re[k] && isEmpty) mUdf[k] = 1'b1;
                if (we[k] && isFull && !re[k]) mOvf[k] = 1'b1;
                if (rdOk) begin
                    mHead[k] = mHead[k] + 1;
                    mCnt[k]  = mCnt[k] - 1;
                end
                if (wr) begin
                    mData[k][6'(mHead[k] + mCnt[k])] = wd[k];
                    mCnt[k] = mCnt[k] + 1;
                end
            end
        end
    end

    // Every falling edge out of reset, compare all outputs of both instances with the model.
    always @(negedge clk) begin
        if (n_rst) begin
            for (int k = 0; k < 2; k++) begin
                int expData;
                expData = (mCnt[k] == 0) ? 0 : int'(mData[k][6'(mHead[k])]);
                checkOutput("count", k, 32'(cnt[k]), mCnt[k]);
                checkOutput("r_data", k, 32'(rd[k]), expData);
                checkOutput("empty", k, 32'(emp[k]), int'(mCnt[k] == 0));
                checkOutput("full", k, 32'(ful[k]), int'(mCnt[k] == depthOf(k)));
                checkOutput("almost_full", k, 32'(af[k]), int'(mCnt[k] >= afOf(k)));
                checkOutput("almost_empty", k, 32'(ae[k]), int'(mCnt[k] <= aeOf(k)));
                checkOutput("overflow", k, 32'(ovf[k]), int'(mOvf[k]));
                checkOutput("underflow", k, 32'(udf[k]), int'(mUdf[k]));
            end
        end
    end

    task automatic randomRun(input int k, input int n, input bit keepBand);
        for (int i = 0; i < n; i++) begin
            logic c, w, r;
            c = 1'b0;
            if (keepBand) begin
                if (mCnt[k] <= 3) begin
                    w = 1'b1; r = 1'b0;
                end else if (mCnt[k] >= 10) begin
                    w = 1'b0; r = 1'b1;
                end else begin
                    case ($urandom_range(0, 2))
                        0:       begin w = 1'b1; r = 1'b0; end
                        1:       begin w = 1'b0; r = 1'b1; end
                        default: begin w = 1'b1; r = 1'b1; end
                    endcase
                end
            end else begin
                w = 1'($urandom_range(0, 1));
                r = 1'($urandom_range(0, 1));
                c = ($urandom_range(0, 31) == 0);
            end
            applyStimulus(k, c, w, 8'($urandom), r);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            clr[k] = 1'b0; we[k] = 1'b0; wd[k] = 8'h00; re[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput("rst_empty", k, 32'(emp[k]), 1);
            checkOutput("rst_full", k, 32'(ful[k]), 0);
            checkOutput("rst_almost_empty", k, 32'(ae[k]), 1);
            checkOutput("rst_almost_full", k, 32'(af[k]), 0);
            checkOutput("rst_count", k, 32'(cnt[k]), 0);
            checkOutput("rst_r_data", k, 32'(rd[k]), 0);
        end
        #11 n_rst = 1'b1;
        @(negedge clk);

        // Fill and drain in order.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 1'b0, 1'b1, 8'(i), 1'b0);
            if (i == 11) checkOutput("af_after_11", 0, 32'(af[0]), 0);
            if (i == 12) checkOutput("af_after_12", 0, 32'(af[0]), 1);
        end
        checkOutput("fill_full", 0, 32'(ful[0]), 1);
        checkOutput("fill_count", 0, 32'(cnt[0]), 16);
        for (int i = 1; i <= 16; i++) begin
            checkOutput("drain_head", 0, 32'(rd[0]), i);
            applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        checkOutput("drain_empty", 0, 32'(emp[0]), 1);
        checkOutput("drain_r_data", 0, 32'(rd[0]), 0);

        // Zero-latency read of a single word.
        applyStimulus(0, 1'b0, 1'b1, 8'hA5, 1'b0);
        checkOutput("fwft_r_data", 0, 32'(rd[0]), 32'hA5);
        checkOutput("fwft_empty", 0, 32'(emp[0]), 0);
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("fwft_pop_empty", 0, 32'(emp[0]), 1);
        checkOutput("fwft_pop_count", 0, 32'(cnt[0]), 0);

        // Full with simultaneous read/write, then a dropped write.
        for (int i = 1; i <= 16; i++) applyStimulus(0, 1'b0, 1'b1, 8'(i), 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 8'h77, 1'b1);
        checkOutput("fullrw_count", 0, 32'(cnt[0]), 16);
        checkOutput("fullrw_head", 0, 32'(rd[0]), 2);
        checkOutput("fullrw_overflow", 0, 32'(ovf[0]), 0);
        applyStimulus(0, 1'b0, 1'b1, 8'h99, 1'b0);
        checkOutput("drop_overflow", 0, 32'(ovf[0]), 1);
        checkOutput("drop_count", 0, 32'(cnt[0]), 16);
        for (int i = 0; i < 16; i++) begin
            checkOutput("fullrw_drain", 0, 32'(rd[0]), (i < 15) ? i + 2 : 32'h77);
            applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b1);
        end

        // Empty with simultaneous read/write, then flush.
        applyStimulus(0, 1'b0, 1'b1, 8'h3C, 1'b1);
        checkOutput("emptyrw_count", 0, 32'(cnt[0]), 1);
        checkOutput("emptyrw_r_data", 0, 32'(rd[0]), 32'h3C);
        checkOutput("emptyrw_underflow", 0, 32'(udf[0]), 1);
        applyStimulus(0, 1'b1, 1'b1, 8'h11, 1'b1);
        checkOutput("clear_count", 0, 32'(cnt[0]), 0);
        checkOutput("clear_underflow", 0, 32'(udf[0]), 0);
        checkOutput("clear_overflow", 0, 32'(ovf[0]), 0);
        checkOutput("clear_empty", 0, 32'(emp[0]), 1);

        // Depth-12 instance: banded traffic across several pointer wraps, then free-running traffic.
        randomRun(1, 100, 1'b1);
        randomRun(1, 400, 1'b0);
        randomRun(0, 400, 1'b0);

        // Async reset between edges with words in flight.
        applyStimulus(0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1'b0, 1'b1, 8'($urandom), 1'b0);
        checkOutput("pre_reset_count", 0, 32'(cnt[0]), 5);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("async_empty", 0, 32'(emp[0]), 1);
        checkOutput("async_count", 0, 32'(cnt[0]), 0);
        checkOutput("async_r_data", 0, 32'(rd[0]), 0);
        @(negedge clk);
        #2 n_rst = 1'b1;
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b1, 8'h5A, 1'b0);
        checkOutput("post_reset_r_data", 0, 32'(rd[0]), 32'h5A);
        checkOutput("post_reset_count", 0, 32'(cnt[0]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
